mem2p11_fifo_ctrl: RTL and testbench

//  Show-ahead FIFO controller for one mem2p11_dxw_u instance (sync write, 1-cycle registered read).

---
 rtl/mem2p11_pkg.sv | 14 +
 rtl/mem2p11_ptr_wrap.sv | 36 +++
 rtl/mem2p11_fifo_ctrl.sv | 111 +++++++++++
 tb/tb_mem2p11_fifo_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mem2p11_pkg.sv
// Shared sizing helpers for the mem2p11 FIFO controller and its pointer sub-module.
package mem2p11_pkg;

    // Address width; a one-word RAM still needs a 1-bit address.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return ($clog2(n) > 0) ? $clog2(n) : 1;
    endfunction

    // Level spans 0..depth+1 because the RAM output register holds one extra word.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/mem2p11_ptr_wrap.sv
// Mod-DEPTH pointer: advances on inc, wraps DEPTH-1 -> 0, synchronous clr to zero.
module mem2p11_ptr_wrap
    import mem2p11_pkg::*;
#(
    parameter int unsigned  DEPTH = 2048,
    localparam int unsigned A     = clog2_min1(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [A-1:0] ptr
);

    logic [A-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == A'(DEPTH - 1)) ? '0 : ptr_q + A'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/mem2p11_fifo_ctrl.sv
// Show-ahead valid/ready FIFO controller around an external sync-write, registered-read RAM.
// Capacity is DEPTH words in RAM plus the word parked on the RAM output register.
module mem2p11_fifo_ctrl
    import mem2p11_pkg::*;
#(
    parameter int unsigned  DEPTH    = 2048,
    parameter int unsigned  WIDTH    = 24,
    parameter int unsigned  AF_LEVEL = DEPTH - 16,
    localparam int unsigned A        = clog2_min1(DEPTH),
    localparam int unsigned L        = level_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [L-1:0]     level,
    output logic             almost_full,
    output logic [A-1:0]     mem_addrw,
    output logic [WIDTH-1:0] mem_din,
    output logic             mem_mew,
    output logic [A-1:0]     mem_addrr,
    output logic             mem_mer,
    input  logic [WIDTH-1:0] mem_dout
);

    logic [L-1:0] mcnt_q, mcnt_d;
    logic [L-1:0] level_q, level_d;
    logic         ov_q, ov_d;
    logic         af_q, af_d;
    logic         wr, pop, fetch;

    always_comb begin
        wr_ready = (mcnt_q != L'(DEPTH)) & ~clr;
        // Block RAM writes while reset is asserted even though wr_ready reads 1.
        wr       = wr_valid & wr_ready & ~rst;
        pop      = ov_q & rd_ready;
        fetch    = (mcnt_q != '0) & (~ov_q | rd_ready) & ~clr;

        mcnt_d = mcnt_q;
        if (wr && !fetch) begin
            mcnt_d = mcnt_q + L'(1);
        end else if (!wr && fetch) begin
            mcnt_d = mcnt_q - L'(1);
        end

        level_d = level_q;
        if (wr && !pop) begin
            level_d = level_q + L'(1);
        end else if (!wr && pop) begin
            level_d = level_q - L'(1);
        end

        ov_d = fetch ? 1'b1 : (pop ? 1'b0 : ov_q);

        if (clr) begin
            mcnt_d  = '0;
            level_d = '0;
            ov_d    = 1'b0;
        end

        af_d = 32'(level_d) >= AF_LEVEL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt_q  <= '0;
            level_q <= '0;
            ov_q    <= 1'b0;
            af_q    <= 1'b0;
        end else begin
            mcnt_q  <= mcnt_d;
            level_q <= level_d;
            ov_q    <= ov_d;
            af_q    <= af_d;
        end
    end

    mem2p11_ptr_wrap #(
        .DEPTH (DEPTH)
    ) u_wptr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (wr),
        .ptr (mem_addrw)
    );

    mem2p11_ptr_wrap #(
        .DEPTH (DEPTH)
    ) u_rptr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (fetch),
        .ptr (mem_addrr)
    );

    assign mem_mew     = wr;
    assign mem_din     = wr_data;
    assign mem_mer     = fetch;
    assign rd_valid    = ov_q;
    assign rd_data     = mem_dout;
    assign level       = level_q;
    assign almost_full = af_q;

endmodule

// File: tb/tb_mem2p11_fifo_ctrl.sv
// Randomised bench for mem2p11_fifo_ctrl with a behavioural RAM and a queue-based reference.
module tb_mem2p11_fifo_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = 8;
    localparam int unsigned AF    = 4;
    localparam int unsigned A     = 2;
    localparam int unsigned L     = 3;

    logic         clk = 1'b0;
    logic         rst, clr, wr_valid, wr_ready, rd_valid, rd_ready, almost_full;
    logic [W-1:0] wr_data, rd_data, mem_din, mem_dout;
    logic [L-1:0] level;
    logic [A-1:0] mem_addrw, mem_addrr;
    logic         mem_mew, mem_mer;

    always #5 clk = ~clk;

    mem2p11_fifo_ctrl #(
        .DEPTH    (DEPTH),
        .WIDTH    (W),
        .AF_LEVEL (AF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .level       (level),
        .almost_full (almost_full),
        .mem_addrw   (mem_addrw),
        .mem_din     (mem_din),
        .mem_mew     (mem_mew),
        .mem_addrr   (mem_addrr),
        .mem_mer     (mem_mer),
        .mem_dout    (mem_dout)
    );

    // Behavioural stand-in for the 2-port RAM: sync write, registered read, dout held when mer=0.
    logic [W-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_mew) ram[mem_addrw] <= mem_din;
        if (mem_mer) mem_dout <= ram[mem_addrr];
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: each held word with the clock edge index at which it was written.
    typedef struct {
        logic [W-1:0] d;
        int           e;
    } ent_t;

    ent_t         mq[$];
    logic [W-1:0] sb_q[$];
    int           cyc   = 0;
    int           waddr = 0;

    // Head is visible once at least one edge has passed since it was written.
    function automatic bit exp_valid();
        return (mq.size() > 0) && (mq[0].e < cyc);
    endfunction

    function automatic void model_clear();
        mq.delete();
        sb_q.delete();
        waddr = 0;
    endfunction

    // Scoreboard monitor: every consumer handshake must deliver the oldest outstanding word.
    always @(negedge clk) begin
        if (!rst && !clr && rd_valid && rd_ready) begin
            if (sb_q.size() == 0) begin
                chk("pop_from_empty_sb", 32'(rd_valid), 32'd0);
            end else begin
                chk("rd_data", 32'(rd_data), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic step(input int pw, input int pr, input int pc);
        bit   ev, er, acc;
        ent_t n;
        @(posedge clk);
        cyc++;
        #1;
        ev = exp_valid();
        chk("level", 32'(level), 32'(mq.size()));
        chk("rd_valid", 32'(rd_valid), 32'(ev));
        chk("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
        wr_valid = ($urandom_range(99) < pw);
        wr_data  = W'($urandom);
        rd_ready = ($urandom_range(99) < pr);
        clr      = ($urandom_range(99) < pc);
        #1;
        er  = !clr && ((mq.size() - int'(ev)) != DEPTH);
        acc = wr_valid && er;
        chk("wr_ready", 32'(wr_ready), 32'(er));
        chk("mem_mew", 32'(mem_mew), 32'(acc));
        if (acc) chk("mem_addrw", 32'(mem_addrw), 32'(waddr % DEPTH));
        if (clr) begin
            model_clear();
        end else begin
            if (ev && rd_ready) void'(mq.pop_front());
            if (acc) begin
                n.d = wr_data;
                n.e = cyc + 1;
                mq.push_back(n);
                sb_q.push_back(wr_data);
                waddr++;
            end
        end
    endtask

    task automatic phase(input int n, input int pw, input int pr, input int pc);
        for (int i = 0; i < n; i++) step(pw, pr, pc);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        clr      = 1'b0;
        rst      = 1'b1;
        #1;
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_mem_mew", 32'(mem_mew), 32'd0);
        chk("rst_mem_mer", 32'(mem_mer), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        rst      = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        clr      = 1'b0;
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        wr_data  = 8'h11;
        #3;
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_wr_ready", 32'(wr_ready), 32'd1);
        chk("reset_mem_mew", 32'(mem_mew), 32'd0);
        chk("reset_mem_mer", 32'(mem_mer), 32'd0);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_almost_full", 32'(almost_full), 32'd0);
        @(negedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        rst      = 1'b0;

        phase(4, 100, 0, 0);    // a few words parked with no consumer
        phase(4, 0, 0, 0);      // head must stay stable
        phase(8, 100, 0, 0);    // fill to full, wr_ready must drop
        phase(8, 0, 100, 0);    // drain in order
        phase(30, 100, 100, 0); // streaming with pointer wrap
        phase(10, 100, 0, 0);   // full again
        phase(12, 100, 100, 0); // push and pop against a full FIFO
        phase(6, 100, 0, 0);
        phase(3, 0, 0, 100);    // flush while words are held
        phase(300, 60, 60, 4);
        phase(10, 100, 100, 0);
        async_reset();
        phase(200, 70, 35, 8);
        phase(200, 40, 80, 2);
        phase(12, 0, 100, 0);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
